// File: rtl/axi_frame_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi_frame_fetch_ctrl_if
// Read-address / read-data channel bundle between the frame fetch sequencer
// and the AXI4 read port, plus the beat strobe fed to the BRAM writer.
//
// Handshake semantics: a transfer happens on a rising clock edge where the
// source holds VALID high and the sink holds READY high. Once VALID is high,
// the source keeps the payload stable until that edge.
//
// Signals:
//   axi_ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  master -> slave, read address
//   axi_ARREADY                               slave  -> master
//   axi_RVALID/RLAST/RRESP                    slave  -> master, read data
//   axi_RREADY                                master -> slave
//   axi_SHAKE                                 master -> writer, RVALID&RREADY
// ---------------------------------------------------------------------------
interface axi_frame_fetch_ctrl_if;
    logic [31:0] axi_ARADDR;
    logic [7:0]  axi_ARLEN;
    logic [2:0]  axi_ARSIZE;
    logic [1:0]  axi_ARBURST;
    logic        axi_ARVALID;
    logic        axi_ARREADY;
    logic        axi_RVALID;
    logic        axi_RLAST;
    logic [1:0]  axi_RRESP;
    logic        axi_RREADY;
    logic        axi_SHAKE;

    modport master (
        output axi_ARADDR, axi_ARLEN, axi_ARSIZE, axi_ARBURST, axi_ARVALID,
        output axi_RREADY, axi_SHAKE,
        input  axi_ARREADY, axi_RVALID, axi_RLAST, axi_RRESP
    );

    modport slave (
        input  axi_ARADDR, axi_ARLEN, axi_ARSIZE, axi_ARBURST, axi_ARVALID,
        input  axi_RREADY, axi_SHAKE,
        output axi_ARREADY, axi_RVALID, axi_RLAST, axi_RRESP
    );
endinterface

// File: rtl/axi_frame_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// axi_frame_fetch_ctrl
// Fetches one frame from DDR into the frame BRAM as NUM_BURSTS fixed-length
// INCR read bursts, one outstanding at a time, then waits for the BRAM writer
// to report completion.
//
// Ports:
//   axi_ACLK, axi_ARESETN  clock, asynchronous active-low reset
//   frame_req, frame_base  one-cycle frame request and DDR byte base address
//   bram_wdone             BRAM writer finished writing the frame
//   busy                   state is not IDLE
//   frame_done             one-cycle pulse on successful completion
//   fetch_err              sticky error, cleared by the next accepted request
//   stage_start            registered level, high while the fetch is active
//   o_dbg_state            current FSM state
//   axi                    AR/R channels and the SHAKE beat strobe
// ---------------------------------------------------------------------------
module axi_frame_fetch_ctrl #(
    parameter int TOTAL_NUM = 1536,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   axi_ACLK,
    input  logic                   axi_ARESETN,
    input  logic                   frame_req,
    input  logic [31:0]            frame_base,
    input  logic                   bram_wdone,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   fetch_err,
    output logic                   stage_start,
    output logic [2:0]             o_dbg_state,
    axi_frame_fetch_ctrl_if.master axi
);
    localparam int NUM_BURSTS = TOTAL_NUM / BURST_LEN;
    localparam int STEP_BYTES = BURST_LEN * 4;
    localparam int ALIGN_BITS = $clog2(STEP_BYTES);
    localparam int BC_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int WC_W       = $clog2(TIMEOUT) + 1;

    localparam logic [31:0]     ADDR_MASK  = ~((32'd1 << ALIGN_BITS) - 32'd1);
    localparam logic [31:0]     ADDR_STEP  = 32'(STEP_BYTES);
    localparam logic [7:0]      ARLEN_VAL  = 8'(BURST_LEN - 1);
    localparam logic [8:0]      LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [BC_W-1:0] LAST_BURST = BC_W'(NUM_BURSTS - 1);
    localparam logic [WC_W-1:0] LAST_WAIT  = WC_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      r_state;
    logic [31:0]     r_araddr;
    logic [BC_W-1:0] r_burst_cnt;
    logic [8:0]      r_beat_cnt;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_fetch_err;
    logic            r_stage_start;
    logic            r_pending;
    logic [31:0]     r_pend_base;

    logic [2:0]      w_next;
    logic            w_accept;
    logic            w_shake;
    logic            w_rlast_hs;
    logic [31:0]     w_start_base;

    assign w_shake      = axi.axi_RVALID & axi.axi_RREADY;
    assign w_rlast_hs   = w_shake & axi.axi_RLAST;
    // A pending request was made first, so its shadowed base wins over a
    // request arriving in the same IDLE cycle (the two merge into one).
    assign w_start_base = r_pending ? r_pend_base : frame_base;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_req || r_pending) begin
                    w_next   = S_ADDR;
                    w_accept = 1'b1;
                end
            end
            S_ADDR: begin
                if (axi.axi_ARREADY) w_next = S_DATA;
            end
            S_DATA: begin
                if (w_rlast_hs) w_next = (r_burst_cnt == LAST_BURST) ? S_WAIT : S_ADDR;
            end
            S_WAIT: begin
                if (bram_wdone)                   w_next = S_DONE;
                else if (r_wait_cnt == LAST_WAIT) w_next = S_IDLE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            r_state       <= S_IDLE;
            r_araddr      <= 32'd0;
            r_burst_cnt   <= '0;
            r_beat_cnt    <= 9'd0;
            r_wait_cnt    <= '0;
            r_fetch_err   <= 1'b0;
            r_stage_start <= 1'b0;
            r_pending     <= 1'b0;
            r_pend_base   <= 32'd0;
        end else begin
            r_state <= w_next;
            // Registered from the next state so DONE and IDLE both read low,
            // giving the writer a clean rising edge on every frame.
            r_stage_start <= (w_next == S_ADDR) || (w_next == S_DATA) || (w_next == S_WAIT);

            // One-deep request queue; anything beyond it is dropped.
            if (w_accept) begin
                r_pending <= 1'b0;
            end else if (frame_req && (r_state != S_IDLE) && !r_pending) begin
                r_pending   <= 1'b1;
                r_pend_base <= frame_base;
            end

            if (w_accept) begin
                r_araddr    <= w_start_base & ADDR_MASK;
                r_burst_cnt <= '0;
                r_beat_cnt  <= 9'd0;
                r_fetch_err <= 1'b0;
            end

            if ((r_state == S_DATA) && w_shake) begin
                if (axi.axi_RLAST) begin
                    r_beat_cnt  <= 9'd0;
                    r_burst_cnt <= r_burst_cnt + BC_W'(1);
                    if (r_burst_cnt != LAST_BURST) r_araddr <= r_araddr + ADDR_STEP;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 9'd1;
                end
                // Short/long bursts and slave errors are flagged but the
                // frame still runs to completion.
                if ((axi.axi_RLAST && (r_beat_cnt != LAST_BEAT)) || (axi.axi_RRESP != 2'b00))
                    r_fetch_err <= 1'b1;
            end

            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
                if (!bram_wdone && (r_wait_cnt == LAST_WAIT)) r_fetch_err <= 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign frame_done  = (r_state == S_DONE);
    assign fetch_err   = r_fetch_err;
    assign stage_start = r_stage_start;
    assign o_dbg_state = r_state;

    assign axi.axi_ARADDR  = r_araddr;
    assign axi.axi_ARLEN   = ARLEN_VAL;
    assign axi.axi_ARSIZE  = 3'b010;
    assign axi.axi_ARBURST = 2'b01;
    assign axi.axi_ARVALID = (r_state == S_ADDR);
    assign axi.axi_RREADY  = (r_state == S_DATA);
    assign axi.axi_SHAKE   = w_shake;
endmodule

// File: doc/axi_frame_fetch_ctrl.md
# axi_frame_fetch_ctrl

Sequencer for the AXI4-FULL read path that fills the frame BRAM. On a frame request it issues fixed-length INCR read bursts over the AR channel, accepts the R channel, drives the handshake and `stage_start` level consumed by the read-data-to-BRAM writer, and waits for that writer's `bram_wdone` before reporting frame completion. It sits between the game/display logic (frame requests) and the AXI master port plus the BRAM write datapath.

## Interface
- `TOTAL_NUM`, 1536, 32-bit words per frame; must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 16, beats per burst (1..256); `ARLEN = BURST_LEN-1`.
- `TIMEOUT`, 1024, cycles allowed in WAIT_DONE before flagging an error.
- `axi_ACLK` in 1: single clock; everything is synchronous to its rising edge.
- `axi_ARESETN` in 1: reset, asynchronous assert, active-low.
- `frame_req` in 1: one-cycle request to fetch a frame.
- `frame_base` in 32: DDR byte address of the frame, sampled on acceptance; bits [1:0] forced to 0.
- `busy` out 1: high whenever state is not IDLE.
- `frame_done` out 1: one-cycle pulse when a frame completes successfully.
- `fetch_err` out 1: sticky error flag; cleared on the next accepted request.
- `stage_start` out 1: level to the BRAM writer, high for the whole fetch.
- `bram_wdone` in 1: BRAM writer reports all words written.
- `axi_ARADDR` out 32, `axi_ARLEN` out 8, `axi_ARSIZE` out 3 (=3'b010), `axi_ARBURST` out 2 (=2'b01), `axi_ARVALID` out 1, `axi_ARREADY` in 1.
- `axi_RVALID` in 1, `axi_RLAST` in 1, `axi_RRESP` in 2, `axi_RREADY` out 1.
- `axi_SHAKE` out 1: `axi_RVALID & axi_RREADY`, combinational, fed to the BRAM writer.

## Operation
- Constants: `NUM_BURSTS = TOTAL_NUM/BURST_LEN` (96 at defaults); address step `BURST_LEN*4` bytes (64).
- States: IDLE, ADDR, DATA, WAIT_DONE, DONE.
- IDLE: `frame_req`, or a pending request, is accepted. Latch `frame_base`, clear `burst_cnt`, `beat_cnt` and `fetch_err`, then go to ADDR.
- ADDR: `axi_ARVALID=1`, with ARADDR/ARLEN held stable. On `axi_ARREADY`, go to DATA.
- DATA: `axi_RREADY=1`. Each handshake increments `beat_cnt`.
  - On a handshake with `axi_RLAST`: if `beat_cnt != BURST_LEN-1`, or on any handshake where `axi_RRESP != 0`, set `fetch_err`. Processing continues either way.
  - After the RLAST handshake: `burst_cnt++`, `beat_cnt=0`. If `burst_cnt == NUM_BURSTS-1`, go to WAIT_DONE. Otherwise add the step to ARADDR and go to ADDR.
- WAIT_DONE: count cycles. If `bram_wdone` is seen, go to DONE. If the count reaches `TIMEOUT`, set `fetch_err` and go to IDLE without `frame_done`.
- DONE: `frame_done=1` for one cycle, then go to IDLE.
- Only one burst is outstanding at a time; no AR is issued until the previous RLAST.
- `stage_start` is registered. It is 1 in ADDR, DATA and WAIT_DONE, and 0 in IDLE and DONE. It is therefore low for at least 2 cycles between frames, so the BRAM writer sees a fresh rising edge.
- A `frame_req` while `busy` sets a one-deep pending flag; further requests while pending are dropped. The pending flag is consumed in IDLE exactly as a new request, using the `frame_base` value present on its original request cycle (latched into a shadow register).
- `frame_req` in IDLE with pending already set: treated as a single request.
- ARADDR arithmetic is 32-bit and wraps modulo 2^32. `frame_base` must be `BURST_LEN*4` aligned so that no burst crosses 4 KB; the low `log2(BURST_LEN*4)` bits are forced to 0.

## Timing
- Reset values:
  - state IDLE; `busy`, `frame_done`, `fetch_err`, `stage_start`, `axi_ARVALID` and `axi_RREADY` all 0.
  - `axi_ARADDR` 0; `axi_ARLEN = BURST_LEN-1`; pending 0.
- `frame_req` at cycle N (IDLE): at N+1, state is ADDR and `busy`, `stage_start` and `axi_ARVALID` are all 1.
- AR accepted at cycle M: `axi_RREADY` is 1 from M+1.
- RLAST handshake at cycle K (not last burst): the next ARVALID is 1 at K+1, with ARADDR advanced by the step.
- Last RLAST at K: WAIT_DONE at K+1. If `bram_wdone` is 1 at cycle W, then `frame_done` is 1 and `stage_start` is 0 at W+1.
- Async reset mid-frame: all outputs return to reset values immediately; pending is cleared; no `frame_done` is produced.

## Test plan
- Single frame at defaults, `frame_base=0x1000_0000`, ARREADY/RVALID always 1, `bram_wdone` 3 cycles after the last RLAST:
  - expect 96 ARs, with ARADDR running 0x1000_0000 to 0x1000_17C0 in 0x40 steps and ARLEN=15;
  - expect 1536 SHAKE pulses, one `frame_done` pulse, and `fetch_err=0`.
- Random ARREADY/RVALID stalls (~50%): ARADDR/ARLEN stay stable while ARVALID is high without ARREADY; beat totals are unchanged.
- Second `frame_req` (base 0x2000_0000) in mid-frame, plus a third request: after the first `frame_done`, `stage_start` is low for 2 cycles, then a frame starts at 0x2000_0000. The third request is dropped.
- Short burst (RLAST on beat 10), or RRESP=2'b10 on one beat: `fetch_err=1`, the frame still completes, and `fetch_err` clears on the next request.
- `bram_wdone` never asserted: `fetch_err=1` after 1024 cycles in WAIT_DONE, return to IDLE, and no `frame_done`.
- Reset asserted during DATA of burst 40: ARVALID, RREADY, `stage_start` and `busy` drop to 0 immediately; after release, a new request starts at burst 0.
